// File: rtl/mux_nx1_pipe_pkg.sv
// Shared constants and helpers for the N:1 registered mux family.
//   MODE_SEL    : explicit channel select via the sel port
//   MODE_RR     : round-robin arbitration among valid inputs
//   clog2_min1  : index width for N channels, never narrower than 1 bit
package mux_nx1_pipe_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter: grants the first requester found searching from ptr
// upward, wrapping modulo N.
//   req        : per-channel request
//   ptr        : highest-priority channel this cycle (must be < N)
//   gnt_valid  : at least one request present
//   gnt_idx    : index of granted channel
//   gnt_onehot : one-hot form of the grant (all zero when no request)
module rr_arbiter_n
  import mux_nx1_pipe_pkg::*;
#(
  parameter  int N  = 4,
  localparam int SW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic          gnt_valid,
  output logic [SW-1:0] gnt_idx,
  output logic [N-1:0]  gnt_onehot
);

  localparam int unsigned NU = N;

  always_comb begin
    int unsigned idx;
    idx        = 0;
    gnt_valid  = 1'b0;
    gnt_idx    = '0;
    gnt_onehot = '0;
    for (int unsigned k = 0; k < NU; k++) begin
      // ptr + k never exceeds 2N-2, so one conditional subtract wraps it
      idx = 32'(ptr) + k;
      if (idx >= NU) idx = idx - NU;
      if (!gnt_valid && req[SW'(idx)]) begin
        gnt_valid               = 1'b1;
        gnt_idx                 = SW'(idx);
        gnt_onehot[SW'(idx)]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_nx1_pipe.sv
// N-way, W-bit selector with a registered output stage and valid/ready
// handshake on both sides.
//   clk, rst   : clock; synchronous active-low reset
//   in_data    : flattened channel data, channel i at [i*W +: W]
//   in_valid   : per-channel valid
//   in_ready   : per-channel ready (combinational, only the granted channel)
//   sel        : explicit channel select (MODE_SEL only)
//   out_data   : registered selected data
//   out_src    : registered index of the channel that supplied out_data
//   out_valid  : output register holds valid data
//   out_ready  : downstream accepts out_data this cycle
module mux_nx1_pipe
  import mux_nx1_pipe_pkg::*;
#(
  parameter  int W    = 5,
  parameter  int N    = 2,
  parameter  int MODE = MODE_SEL,
  localparam int SW   = clog2_min1(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_src,
  output logic           out_valid,
  input  logic           out_ready
);

  logic          load;
  logic          gnt_ok;
  logic          xfer;
  logic [SW-1:0] gnt;
  logic [N-1:0]  gnt_oh;
  logic [W-1:0]  gnt_data;

  // Gating with rst keeps in_ready low while reset is held, since any
  // transfer in that cycle would be discarded anyway.
  assign load = rst && (!out_valid || out_ready);

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic [SW-1:0] ptr;
      logic          unused_sel;

      assign unused_sel = ^sel;

      rr_arbiter_n #(.N(N)) u_arb (
        .req        (in_valid),
        .ptr        (ptr),
        .gnt_valid  (gnt_ok),
        .gnt_idx    (gnt),
        .gnt_onehot (gnt_oh)
      );

      // Pointer moves past the winner only on an actual transfer.
      always_ff @(posedge clk) begin
        if (!rst)      ptr <= '0;
        else if (xfer) ptr <= (32'(gnt) == N - 1) ? '0 : gnt + 1'b1;
      end
    end else begin : g_sel
      assign gnt = sel;

      // Out-of-range sel decodes to no grant at all.
      always_comb begin
        gnt_oh = '0;
        for (int unsigned i = 0; i < N; i++) begin
          gnt_oh[i] = (32'(sel) == i);
        end
      end

      assign gnt_ok = |gnt_oh;
    end
  endgenerate

  assign in_ready = load ? gnt_oh : '0;
  assign xfer     = gnt_ok && |(in_valid & in_ready);

  always_comb begin
    gnt_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt_oh[i]) gnt_data = in_data[i*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= gnt_data;
      out_src   <= gnt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Bench for mux_nx1_pipe: three instances (explicit N=2, round-robin N=4,
// explicit N=3) share one clock and reset. A per-instance reference model
// is checked every cycle, with directed literal checks on top.
module tb_mux_nx1_pipe;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Instance A: MODE=0, N=2
  logic [9:0]  a_data;  logic [1:0] a_valid, a_ready; logic [0:0] a_sel;
  logic [4:0]  a_odata; logic [0:0] a_osrc; logic a_ovalid, a_oready;
  // Instance B: MODE=1, N=4
  logic [19:0] b_data;  logic [3:0] b_valid, b_ready; logic [1:0] b_sel;
  logic [4:0]  b_odata; logic [1:0] b_osrc; logic b_ovalid, b_oready;
  // Instance C: MODE=0, N=3
  logic [14:0] c_data;  logic [2:0] c_valid, c_ready; logic [1:0] c_sel;
  logic [4:0]  c_odata; logic [1:0] c_osrc; logic c_ovalid, c_oready;

  mux_nx1_pipe #(.W(5), .N(2), .MODE(0)) dut_a (
    .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .sel(a_sel), .out_data(a_odata), .out_src(a_osrc), .out_valid(a_ovalid), .out_ready(a_oready));
  mux_nx1_pipe #(.W(5), .N(4), .MODE(1)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .sel(b_sel), .out_data(b_odata), .out_src(b_osrc), .out_valid(b_ovalid), .out_ready(b_oready));
  mux_nx1_pipe #(.W(5), .N(3), .MODE(0)) dut_c (
    .clk(clk), .rst(rst), .in_data(c_data), .in_valid(c_valid), .in_ready(c_ready),
    .sel(c_sel), .out_data(c_odata), .out_src(c_osrc), .out_valid(c_ovalid), .out_ready(c_oready));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Generic views of the three instances for the model.
  int          n_of[3]    = '{2, 4, 3};
  int          mode_of[3] = '{0, 1, 0};
  logic [3:0]  g_v[3];
  logic [4:0]  g_d[3][4];
  int          g_sel[3];
  logic        g_or[3];
  logic        g_ov[3];
  logic [4:0]  g_od[3];
  int          g_os[3];
  logic [3:0]  g_rdy[3];

  always_comb begin
    for (int d = 0; d < 3; d++) for (int i = 0; i < 4; i++) g_d[d][i] = '0;
    g_v[0] = {2'b00, a_valid}; g_v[1] = b_valid; g_v[2] = {1'b0, c_valid};
    for (int i = 0; i < 2; i++) g_d[0][i] = a_data[i*5 +: 5];
    for (int i = 0; i < 4; i++) g_d[1][i] = b_data[i*5 +: 5];
    for (int i = 0; i < 3; i++) g_d[2][i] = c_data[i*5 +: 5];
    g_sel[0] = int'(a_sel); g_sel[1] = int'(b_sel); g_sel[2] = int'(c_sel);
    g_or[0] = a_oready; g_or[1] = b_oready; g_or[2] = c_oready;
    g_ov[0] = a_ovalid; g_ov[1] = b_ovalid; g_ov[2] = c_ovalid;
    g_od[0] = a_odata;  g_od[1] = b_odata;  g_od[2] = c_odata;
    g_os[0] = int'(a_osrc); g_os[1] = int'(b_osrc); g_os[2] = int'(c_osrc);
    g_rdy[0] = {2'b00, a_ready}; g_rdy[1] = b_ready; g_rdy[2] = {1'b0, c_ready};
  end

  // Which channel the rules say should be chosen, or -1 for none.
  function automatic int pick(input int mode, input int n, input int sel,
                              input int ptr, input logic [3:0] v);
    if (mode == 0) return (sel < n) ? sel : -1;
    for (int k = 0; k < n; k++) begin
      if (v[(ptr + k) % n]) return (ptr + k) % n;
    end
    return -1;
  endfunction

  bit       started = 0;
  bit       mv[3];
  int       md[3];
  int       ms[3];
  int       mp[3];

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      int g;
      bit ld;
      if (!rst) begin
        mv[d] = 0; md[d] = 0; ms[d] = 0; mp[d] = 0;
      end else begin
        g  = pick(mode_of[d], n_of[d], g_sel[d], mp[d], g_v[d]);
        ld = !mv[d] || g_or[d];
        if (g >= 0 && ld && g_v[d][g]) begin
          mv[d] = 1; md[d] = int'(g_d[d][g]); ms[d] = g;
          if (mode_of[d] == 1) mp[d] = (g + 1) % n_of[d];
        end else if (g_or[d]) begin
          mv[d] = 0;
        end
      end
    end
    started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int d = 0; d < 3; d++) begin
        int g;
        int er;
        g  = pick(mode_of[d], n_of[d], g_sel[d], mp[d], g_v[d]);
        er = (rst && (!mv[d] || g_or[d]) && g >= 0) ? (1 << g) : 0;
        chk($sformatf("m%0d_in_ready", d), int'(g_rdy[d]), er);
        chk($sformatf("m%0d_out_valid", d), int'(g_ov[d]), int'(mv[d]));
        chk($sformatf("m%0d_out_data", d), int'(g_od[d]), md[d]);
        chk($sformatf("m%0d_out_src", d), g_os[d], ms[d]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    // Reset held two cycles with everything valid and drained.
    a_data = '0; a_valid = '1; a_sel = 1'b0; a_oready = 1'b1;
    b_data = '0; b_valid = '1; b_sel = '0;   b_oready = 1'b1;
    c_data = '0; c_valid = '1; c_sel = '0;   c_oready = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_a_out_valid", int'(a_ovalid), 0);
      chk("rst_a_out_data", int'(a_odata), 0);
      chk("rst_a_out_src", int'(a_osrc), 0);
      chk("rst_a_in_ready", int'(a_ready), 0);
      chk("rst_b_in_ready", int'(b_ready), 0);
    end
    rst = 1'b1;
    b_valid = '0; c_valid = '0;

    // Explicit select, channel 1 of two.
    a_sel = 1'b1; a_data = {5'h1A, 5'h03}; a_valid = 2'b11; a_oready = 1'b1;
    #1 chk("a_accept_in_ready", int'(a_ready), 2);
    tick();
    chk("a_first_data", int'(a_odata), 'h1A);
    chk("a_first_src", int'(a_osrc), 1);
    chk("a_first_valid", int'(a_ovalid), 1);

    // Back-pressure: output must hold while inputs change.
    a_oready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_data = {5'(i + 5), 5'(i + 9)};
      #1 chk("a_bp_in_ready", int'(a_ready), 0);
      tick();
      chk("a_bp_hold_data", int'(a_odata), 'h1A);
    end
    a_oready = 1'b1; a_data = {5'h11, 5'h02};
    #1 chk("a_drain_in_ready", int'(a_ready), 2);
    tick();
    chk("a_nobubble_data", int'(a_odata), 'h11);
    chk("a_nobubble_valid", int'(a_ovalid), 1);
    a_valid = 2'b00;
    tick();
    chk("a_empty_valid", int'(a_ovalid), 0);
    chk("a_empty_hold_data", int'(a_odata), 'h11);

    // Round-robin over four always-valid channels.
    b_data = {5'h13, 5'h12, 5'h11, 5'h10}; b_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("b_rr_src", int'(b_osrc), exp_seq[i]);
      chk("b_rr_data", int'(b_odata), 'h10 + exp_seq[i]);
    end
    b_valid = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("b_single_src", int'(b_osrc), 2);
    end
    // Grant channel 1 so the pointer lands on 2, then reset mid-stream.
    b_valid = 4'b0010;
    tick();
    chk("b_pre_rst_src", int'(b_osrc), 1);
    b_valid = 4'b1111; rst = 1'b0;
    #1 chk("b_rst_in_ready", int'(b_ready), 0);
    tick();
    chk("b_rst_valid", int'(b_ovalid), 0);
    chk("b_rst_src", int'(b_osrc), 0);
    rst = 1'b1;
    tick();
    chk("b_after_rst_src", int'(b_osrc), 0);
    chk("b_after_rst_valid", int'(b_ovalid), 1);
    b_valid = '0;

    // Explicit select with an out-of-range sel on three channels.
    c_data = {5'h0A, 5'h09, 5'h08}; c_valid = 3'b111; c_sel = 2'd0; c_oready = 1'b0;
    tick();
    chk("c_load_data", int'(c_odata), 'h08);
    chk("c_load_valid", int'(c_ovalid), 1);
    c_sel = 2'd3;
    #1 chk("c_oor_in_ready", int'(c_ready), 0);
    tick();
    chk("c_oor_hold_valid", int'(c_ovalid), 1);
    c_oready = 1'b1;
    #1 chk("c_oor_drain_ready", int'(c_ready), 0);
    tick();
    chk("c_oor_drained_valid", int'(c_ovalid), 0);
    chk("c_oor_hold_data", int'(c_odata), 'h08);
    c_sel = 2'd2;
    tick();
    chk("c_top_src", int'(c_osrc), 2);
    chk("c_top_data", int'(c_odata), 'h0A);

    // Mixed traffic, checked by the model alone.
    for (int i = 0; i < 80; i++) begin
      a_valid = 2'($urandom); a_sel = 1'($urandom); a_oready = 1'($urandom);
      a_data = 10'($urandom);
      b_valid = 4'($urandom); b_oready = 1'($urandom); b_data = 20'($urandom);
      c_valid = 3'($urandom); c_sel = 2'($urandom); c_oready = 1'($urandom);
      c_data = 15'($urandom);
      rst = ($urandom_range(0, 19) != 0);
      tick();
    end
    rst = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_nx1_pipe.md
Name: mux_nx1_pipe

Overview:
- Parametrised successor to the team's fixed 2:1 5-bit combinational select muxes: N-way, W-bit selector with a registered output stage and valid/ready handshake.
- Two selection modes: explicit select (MODE=0) and round-robin arbitration among valid inputs (MODE=1).
- Used in the KGP-RISC datapath where a multi-source field is muxed (e.g. destination-register choice among ALU/load/link writers) and must be registered and back-pressurable.

Parameters:
- W, 5, data width per channel.
- N, 2, number of input channels (N >= 2).
- MODE, 0, 0 = explicit select via sel; 1 = round-robin arbitration, sel ignored.
- SW, $clog2(N), select/index width (derived localparam, minimum 1).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous active-low reset.
- in_data  input  N*W  flattened channel data; channel i occupies bits [i*W +: W].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready (combinational).
- sel  input  SW  channel select, used only when MODE=0.
- out_data  output  W  registered selected data.
- out_src  output  SW  registered index of the channel that supplied out_data.
- out_valid  output  1  output register holds valid data.
- out_ready  input  1  downstream accepts out_data this cycle.

Behaviour:
- Reset (rst==0 at clk edge): out_valid=0, out_data=0, out_src=0, rr pointer=0. Reset wins over any simultaneous transfer. A held output is discarded by reset mid-operation.
- load = !out_valid || out_ready. The output register can take new data when empty or when being drained in the same cycle.
- MODE=0:
  - gnt = sel when sel < N.
  - in_ready[i] = load && (i == sel); all other in_ready bits = 0.
  - sel >= N: no grant, all in_ready=0, no load.
- MODE=1:
  - gnt = first i with in_valid[i]=1, searching ptr, ptr+1, …, N-1, 0, …, ptr-1 (wrap modulo N).
  - in_ready[gnt] = load; all others 0. No valid input: all in_ready=0.
- Transfer on channel g happens when in_valid[g] && in_ready[g]. At the next edge: out_data <= in_data[g*W +: W], out_src <= g, out_valid <= 1. In MODE=1, ptr <= (g==N-1) ? 0 : g+1.
- No transfer and out_ready=1: out_valid <= 0. out_data and out_src hold their last values.
- No transfer and out_ready=0: all outputs hold.
- Latency: 1 cycle input-to-output. Throughput: 1 word/cycle under continuous out_ready=1.
- ptr changes only on a transfer. out_ready toggling never moves ptr.
- in_ready is a function of out_valid, out_ready, in_valid and sel only. It must not depend on in_ready of the same channel (no combinational loop).
- out_data must not change while out_valid=1 && out_ready=0.

Decomposition:
- Shared package constants: MODE_SEL=0, MODE_RR=1, plus a clog2-min-1 helper for SW.
- One natural sub-module: rr_arbiter_n (N-bit request, pointer, one-hot/index grant). Instantiated only when MODE=1. MODE=0 uses direct decode.

Test Plan:
- Reset: hold rst=0 for 2 cycles with in_valid=all 1 and out_ready=1 -> out_valid=0, out_data=0, out_src=0, in_ready=0 throughout.
- MODE=0, N=2, W=5: sel=1, in_data={5'h1A,5'h03}, in_valid=2'b11, out_ready=1 -> next cycle out_data=5'h1A, out_src=1, out_valid=1, in_ready=2'b10 during the accept cycle.
- Back-pressure: out_valid=1 with out_data=5'h1A, out_ready=0 for 3 cycles while in_data changes -> out_data stays 5'h1A, in_ready=0. Then out_ready=1 -> new word loads the same cycle, no bubble.
- MODE=1, N=4: in_valid=4'b1111 constant, out_ready=1 -> out_src sequence 0,1,2,3,0. Then in_valid=4'b0100 -> out_src=2 repeatedly.
- MODE=0, N=3: sel=3 (out of range), in_valid=3'b111 -> in_ready=0, out_valid deasserts after the pending word drains.
- Reset mid-stream: MODE=1 with ptr=2 and out_valid=1, assert rst=0 for one cycle -> out_valid=0 and ptr=0. First grant after release goes to channel 0 when all channels are valid.
